// File: rtl/signed_product_accumulator_pkg.sv
// Shared types and helpers for the signed product accumulator and its adder.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package signed_product_accumulator_pkg;

    // Two-state frame controller: gather products, then present the result.
    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Largest value representable in a w-bit two's-complement word.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a w-bit two's-complement word.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/signed_product_accumulator_if.sv
// Handshake bundle between the multiplier, the accumulator and its consumer.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready carry flow control in each direction.
interface signed_product_accumulator_if #(
    parameter int n     = 4,
    parameter int m     = 4,
    parameter int ACC_W = 10,
    parameter int LEN   = 4
) ();
    localparam int CNT_W = $clog2(LEN + 1);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [n+m-1:0]   P;
    logic                    clr;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] ACC;
    logic                    ovf;
    logic [CNT_W-1:0]        cnt;

    // Producer of products / consumer of results.
    modport master (
        output in_valid, P, clr, out_ready,
        input  in_ready, out_valid, ACC, ovf, cnt
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, P, clr, out_ready,
        output in_ready, out_valid, ACC, ovf, cnt
    );
endinterface

// File: rtl/signed_sat_add.sv
// Combinational signed add of a and b, clamped to a W_S-bit signed result.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ovf flags that the result was clamped.
module signed_sat_add
    import signed_product_accumulator_pkg::*;
#(
    parameter int W_A = 10,
    parameter int W_B = 8,
    parameter int W_S = 10
) (
    input  logic signed [W_A-1:0] a,
    input  logic signed [W_B-1:0] b,
    output logic signed [W_S-1:0] s,
    output logic                  ovf
);
    // One guard bit above the widest operand/result keeps the raw sum exact.
    localparam int W_AB = (W_A > W_B) ? W_A : W_B;
    localparam int W_X  = ((W_AB > W_S) ? W_AB : W_S) + 1;

    localparam logic signed [W_X-1:0] SMAX = W_X'(sat_max(W_S));
    localparam logic signed [W_X-1:0] SMIN = W_X'(sat_min(W_S));

    logic signed [W_X-1:0] a_x;
    logic signed [W_X-1:0] b_x;
    logic signed [W_X-1:0] sum;

    assign a_x = {{(W_X - W_A){a[W_A-1]}}, a};
    assign b_x = {{(W_X - W_B){b[W_B-1]}}, b};
    assign sum = a_x + b_x;

    // Clamp the exact sum into the result range and flag any clamping.
    always_comb begin
        s   = sum[W_S-1:0];
        ovf = 1'b0;
        if (sum > SMAX) begin
            s   = SMAX[W_S-1:0];
            ovf = 1'b1;
        end else if (sum < SMIN) begin
            s   = SMIN[W_S-1:0];
            ovf = 1'b1;
        end
    end
endmodule

// File: rtl/signed_product_accumulator.sv
// Sums LEN signed products per frame into a saturating ACC_W-bit result.
// Latency: ACC updates 1 cycle after each accept; out_valid 1 cycle after the LEN-th.
// Backpressure: in_ready drops while a result waits; held until out_ready or clr.
module signed_product_accumulator
    import signed_product_accumulator_pkg::*;
#(
    parameter int n     = 4,
    parameter int m     = 4,
    parameter int ACC_W = 10,
    parameter int LEN   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    signed_product_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    // A narrower accumulator than a single product cannot hold its own input.
    if (ACC_W < n + m) begin : g_bad_acc_w
        $error("signed_product_accumulator: ACC_W must be >= n+m");
    end
    if (LEN < 1) begin : g_bad_len
        $error("signed_product_accumulator: LEN must be >= 1");
    end

    state_t                  state, state_d;
    logic signed [ACC_W-1:0] acc,   acc_d;
    logic [CNT_W-1:0]        cnt,   cnt_d;
    logic                    ovf,   ovf_d;

    logic signed [ACC_W-1:0] sat_sum;
    logic                    sat_ovf;

    signed_sat_add #(
        .W_A (ACC_W),
        .W_B (n + m),
        .W_S (ACC_W)
    ) u_add (
        .a   (acc),
        .b   (bus.P),
        .s   (sat_sum),
        .ovf (sat_ovf)
    );

    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.ACC       = acc;
    assign bus.ovf       = ovf;
    assign bus.cnt       = cnt;

    // Frame registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            ovf   <= ovf_d;
        end
    end

    // Next frame state: clr aborts; otherwise accumulate or wait for the handshake.
    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        ovf_d   = ovf;
        if (bus.clr) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (bus.in_valid) begin
                        acc_d = sat_sum;
                        ovf_d = ovf | sat_ovf;
                        cnt_d = cnt + CNT_W'(1);
                        if (cnt == CNT_LAST) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_ACCUM;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_signed_product_accumulator.sv
// Drives a 10-bit and an 8-bit accumulator with identical stimulus.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven per scenario and randomly.
module tb_signed_product_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchecks = 0;
    int   nerrors = 0;

    localparam int LEN = 4;

    signed_product_accumulator_if #(.n(4), .m(4), .ACC_W(10), .LEN(LEN)) ifa ();
    signed_product_accumulator_if #(.n(4), .m(4), .ACC_W(8),  .LEN(LEN)) ifb ();

    signed_product_accumulator #(.n(4), .m(4), .ACC_W(10), .LEN(LEN)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    signed_product_accumulator #(.n(4), .m(4), .ACC_W(8), .LEN(LEN)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    always #5 clk = ~clk;

    // Reference: products accepted in the current frame, and whether it is complete.
    int q[$];
    bit hold = 1'b0;

    // Saturating running sum of the frame for a w-bit accumulator.
    function automatic int fold(input int w, output bit ov);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        int acc = 0;
        ov = 1'b0;
        foreach (q[i]) begin
            acc = acc + q[i];
            if (acc > hi) begin acc = hi; ov = 1'b1; end
            else if (acc < lo) begin acc = lo; ov = 1'b1; end
        end
        return acc;
    endfunction

    // Apply one clock of stimulus to both DUTs and advance the reference.
    task automatic step(input bit rst, input bit v, input int p, input bit c, input bit ordy);
        logic [7:0] pb;
        pb = p[7:0];
        rst_n = ~rst;
        ifa.in_valid = v; ifa.P = pb; ifa.clr = c; ifa.out_ready = ordy;
        ifb.in_valid = v; ifb.P = pb; ifb.clr = c; ifb.out_ready = ordy;
        @(posedge clk);
        if (rst || c) begin
            q.delete(); hold = 1'b0;
        end else if (!hold) begin
            if (v) begin
                q.push_back(int'($signed(pb)));
                if (q.size() == LEN) hold = 1'b1;
            end
        end else if (ordy) begin
            q.delete(); hold = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 37, 0, 0);
        step(1, 1, -20, 0, 1);
        nchecks++; if ($signed(ifa.ACC) !== 0) begin nerrors++; $display("FAIL reset_acc: got %0d want 0", $signed(ifa.ACC)); end
        nchecks++; if (ifa.cnt !== 0) begin nerrors++; $display("FAIL reset_cnt: got %0d want 0", ifa.cnt); end
        nchecks++; if (ifa.ovf !== 1'b0 || ifa.out_valid !== 1'b0) begin nerrors++; $display("FAIL reset_flags: ovf=%b out_valid=%b want 0 0", ifa.ovf, ifa.out_valid); end
        step(0, 0, 0, 0, 0);
        nchecks++; if (ifa.in_ready !== 1'b1) begin nerrors++; $display("FAIL reset_in_ready: got %b want 1", ifa.in_ready); end
    endtask

    task automatic test_frame();
        int ps[4] = '{-12, 6, 64, -56};
        int e; bit ov;
        foreach (ps[i]) begin
            step(0, 1, ps[i], 0, 0);
            e = fold(10, ov);
            nchecks++; if ($signed(ifa.ACC) !== e) begin nerrors++; $display("FAIL frame_acc[%0d]: got %0d want %0d", i, $signed(ifa.ACC), e); end
            nchecks++; if (ifa.out_valid !== (i == 3)) begin nerrors++; $display("FAIL frame_out_valid[%0d]: got %b want %b", i, ifa.out_valid, i == 3); end
        end
        nchecks++; if ($signed(ifa.ACC) !== 2 || ifa.ovf !== 1'b0 || ifa.cnt !== 4) begin nerrors++; $display("FAIL frame_result: acc=%0d ovf=%b cnt=%0d want 2 0 4", $signed(ifa.ACC), ifa.ovf, ifa.cnt); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 5, 0, 0);
            nchecks++; if (ifa.in_ready !== 1'b0 || $signed(ifa.ACC) !== 2 || ifa.out_valid !== 1'b1) begin nerrors++; $display("FAIL bp_hold[%0d]: in_ready=%b acc=%0d out_valid=%b want 0 2 1", i, ifa.in_ready, $signed(ifa.ACC), ifa.out_valid); end
        end
        step(0, 1, 5, 0, 1);
        nchecks++; if (ifa.out_valid !== 1'b0 || $signed(ifa.ACC) !== 0 || ifa.in_ready !== 1'b1 || ifa.cnt !== 0) begin nerrors++; $display("FAIL bp_release: out_valid=%b acc=%0d in_ready=%b cnt=%0d want 0 0 1 0", ifa.out_valid, $signed(ifa.ACC), ifa.in_ready, ifa.cnt); end
    endtask

    task automatic test_saturation();
        int frames[3][4] = '{'{64, 64, 64, 64}, '{-56, -56, -56, -56}, '{-12, 6, 64, -56}};
        int want_acc[3] = '{127, -128, 2};
        bit want_ovf[3] = '{1'b1, 1'b1, 1'b0};
        int e; bit ov;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) step(0, 1, frames[f][i], 0, 0);
            e = fold(8, ov);
            nchecks++; if ($signed(ifb.ACC) !== want_acc[f] || $signed(ifb.ACC) !== e) begin nerrors++; $display("FAIL sat_acc[%0d]: got %0d want %0d", f, $signed(ifb.ACC), want_acc[f]); end
            nchecks++; if (ifb.ovf !== want_ovf[f]) begin nerrors++; $display("FAIL sat_ovf[%0d]: got %b want %b", f, ifb.ovf, want_ovf[f]); end
            step(0, 0, 0, 0, 1);
            nchecks++; if (ifb.ovf !== 1'b0) begin nerrors++; $display("FAIL sat_ovf_clear[%0d]: got %b want 0", f, ifb.ovf); end
        end
    endtask

    task automatic test_gaps_clr();
        step(0, 1, 10, 0, 0);
        step(0, 0, 99, 0, 0);
        step(0, 1, 20, 0, 0);
        nchecks++; if ($signed(ifa.ACC) !== 30 || ifa.cnt !== 2) begin nerrors++; $display("FAIL gap_acc: acc=%0d cnt=%0d want 30 2", $signed(ifa.ACC), ifa.cnt); end
        step(0, 1, 7, 1, 0);
        nchecks++; if ($signed(ifa.ACC) !== 0 || ifa.cnt !== 0) begin nerrors++; $display("FAIL clr: acc=%0d cnt=%0d want 0 0", $signed(ifa.ACC), ifa.cnt); end
        for (int i = 1; i <= 4; i++) step(0, 1, i, 0, 0);
        nchecks++; if ($signed(ifa.ACC) !== 10 || ifa.out_valid !== 1'b1) begin nerrors++; $display("FAIL post_clr_frame: acc=%0d out_valid=%b want 10 1", $signed(ifa.ACC), ifa.out_valid); end
    endtask

    task automatic test_reset_hold();
        step(1, 1, 3, 0, 1);
        nchecks++; if ($signed(ifa.ACC) !== 0 || ifa.cnt !== 0 || ifa.ovf !== 1'b0 || ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin nerrors++; $display("FAIL reset_hold: acc=%0d cnt=%0d ovf=%b out_valid=%b in_ready=%b want 0 0 0 0 1", $signed(ifa.ACC), ifa.cnt, ifa.ovf, ifa.out_valid, ifa.in_ready); end
        step(0, 1, 9, 0, 1);
        nchecks++; if ($signed(ifa.ACC) !== 9 || ifa.cnt !== 1) begin nerrors++; $display("FAIL reset_hold_next: acc=%0d cnt=%0d want 9 1", $signed(ifa.ACC), ifa.cnt); end
    endtask

    task automatic test_random();
        int ea, eb; bit oa, ob;
        for (int i = 0; i < 400; i++) begin
            step(0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
                 $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
            ea = fold(10, oa);
            eb = fold(8, ob);
            nchecks++;
            if ($signed(ifa.ACC) !== ea || ifa.ovf !== oa || $signed(ifb.ACC) !== eb || ifb.ovf !== ob) begin
                nerrors++;
                $display("FAIL rand_acc[%0d]: a=%0d/%b b=%0d/%b want %0d/%b %0d/%b", i, $signed(ifa.ACC), ifa.ovf, $signed(ifb.ACC), ifb.ovf, ea, oa, eb, ob);
            end
            nchecks++;
            if (ifa.cnt !== q.size() || ifa.out_valid !== hold || ifa.in_ready !== !hold || ifb.out_valid !== hold) begin
                nerrors++;
                $display("FAIL rand_ctl[%0d]: cnt=%0d out_valid=%b in_ready=%b want %0d %b %b", i, ifa.cnt, ifa.out_valid, ifa.in_ready, q.size(), hold, !hold);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_saturation();
        test_gaps_clr();
        test_reset_hold();
        step(1, 0, 0, 0, 0);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
